tv80_dma_arbiter: RTL and testbench

- Bus-master controller that shares the tv80s 64 KiB memory between the CPU and a block-copy/fill DMA engine.
- Takes the bus via busrq_n/busak_n, muxes the memory port to itself, moves bytes, then releases the bus.
- Sits between tv80s and the memory array in system tops and benches; testbenches also use it to preload and inspect memory without stopping simulation.

---
 rtl/tv80_dma_pkg.sv | 27 ++
 rtl/tv80_dma_busmux.sv | 32 +++
 rtl/tv80_dma_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_tv80_dma_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tv80_dma_pkg.sv
// Shared types and constants for the tv80 DMA bus-master arbiter.
// The optional interrupt feature is enabled with the TV80_DMA_IRQ_EN macro.
package tv80_dma_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      RD       = 3'd2,
      WR       = 3'd3,
      REL      = 3'd4,
      REL_LAST = 3'd5,
      HOLD     = 3'd6,
      FIN      = 3'd7
   } dma_state_t;

   // Addresses wrap naturally at the top of the 64 KiB space.
   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return a + {{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/tv80_dma_busmux.sv
// Memory-port multiplexer: the CPU owns the port unless the DMA holds grant.
module tv80_dma_busmux
   import tv80_dma_pkg::*;
(
   input  logic              grant,
   input  logic [ADDR_W-1:0] cpu_a,
   input  logic [DATA_W-1:0] cpu_do,
   input  logic              cpu_mreq_n,
   input  logic              cpu_wr_n,
   input  logic [ADDR_W-1:0] dma_a,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we
);

   // Select the port owner.
   always_comb begin
      mem_a     = cpu_a;
      mem_wdata = cpu_do;
      mem_we    = 1'b0;
      if (grant) begin
         mem_a     = dma_a;
         mem_wdata = dma_wdata;
         mem_we    = dma_we;
      end else begin
         mem_we    = ~cpu_mreq_n & ~cpu_wr_n;
      end
   end

endmodule

// File: rtl/tv80_dma_arbiter.sv
// Block copy/fill DMA that borrows the tv80s memory port via busrq_n/busak_n.
// Define TV80_DMA_IRQ_EN to add a sticky completion interrupt (int_n/int_ack).
module tv80_dma_arbiter
   import tv80_dma_pkg::*;
#(
   parameter int BURST_MAX = 16,
   parameter int HOLDOFF   = 4
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [15:0]       len,
   input  logic [DATA_W-1:0] fill_val,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] cpu_a,
   input  logic [DATA_W-1:0] cpu_do,
   input  logic              cpu_mreq_n,
   input  logic              cpu_wr_n,
   output logic              cpu_busrq_n,
   input  logic              cpu_busak_n,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef TV80_DMA_IRQ_EN
   ,
   output logic              int_n,
   input  logic              int_ack
`endif
);

   localparam logic [15:0] BURST_LIM = 16'(BURST_MAX);
   localparam int          HOLD_CYC  = (HOLDOFF < 1) ? 1 : HOLDOFF;
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);

   dma_state_t        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [15:0]       len_q, len_d, burst_q, burst_d, hold_q, hold_d;
   logic              mode_q, mode_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              busrq_n_q, busrq_n_d, grant_q, grant_d;
   logic              grant_s, dma_we_s;
   logic [ADDR_W-1:0] dma_a_s;
   logic [DATA_W-1:0] dma_wdata_s;

   // Next-state, counter update and DMA-side port drive.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      len_d       = len_q;
      mode_d      = mode_q;
      fill_d      = fill_q;
      burst_d     = burst_q;
      hold_d      = hold_q;
      dma_a_s     = '0;
      dma_wdata_s = '0;
      dma_we_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               src_d  = src;
               dst_d  = dst;
               len_d  = len;
               mode_d = mode;
               fill_d = fill_val;
               if (len == 16'd0) begin
                  state_d = FIN;
               end else begin
                  state_d = REQ;
               end
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (!cpu_busak_n) begin
               state_d = (mode_q == MODE_FILL) ? WR : RD;
            end else begin
               state_d = REQ;
            end
         end
         RD: begin
            // Losing busak while granted restarts the request with counters untouched.
            if (cpu_busak_n) begin
               state_d = REQ;
            end else begin
               dma_a_s = src_q;
               state_d = WR;
            end
         end
         WR: begin
            if (cpu_busak_n) begin
               state_d = REQ;
            end else begin
               dma_a_s     = dst_q;
               dma_we_s    = 1'b1;
               dma_wdata_s = (mode_q == MODE_FILL) ? fill_q : mem_rdata;
               src_d       = addr_inc(src_q);
               dst_d       = addr_inc(dst_q);
               len_d       = len_q - 16'd1;
               burst_d     = burst_q + 16'd1;
               if (len_q == 16'd1) begin
                  state_d = REL_LAST;
               end else if ((BURST_LIM != 16'd0) && (burst_d == BURST_LIM)) begin
                  state_d = REL;
               end else begin
                  state_d = (mode_q == MODE_FILL) ? WR : RD;
               end
            end
         end
         REL: begin
            burst_d = 16'd0;
            hold_d  = 16'd0;
            if (cpu_busak_n) begin
               state_d = HOLD;
            end else begin
               state_d = REL;
            end
         end
         REL_LAST: begin
            burst_d = 16'd0;
            if (cpu_busak_n) begin
               state_d = FIN;
            end else begin
               state_d = REL_LAST;
            end
         end
         HOLD: begin
            burst_d = 16'd0;
            if (hold_q == HOLD_LAST) begin
               hold_d  = 16'd0;
               state_d = REQ;
            end else begin
               hold_d  = hold_q + 16'd1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d    = (state_d != IDLE) && (state_d != FIN);
      done_d    = (state_d == FIN);
      busrq_n_d = !((state_d == REQ) || (state_d == RD) || (state_d == WR));
      grant_d   = (state_d == RD) || (state_d == WR);
   end

   // State, datapath and registered output flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= 16'd0;
         mode_q    <= MODE_COPY;
         fill_q    <= '0;
         burst_q   <= 16'd0;
         hold_q    <= 16'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         busrq_n_q <= 1'b1;
         grant_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         fill_q    <= fill_d;
         burst_q   <= burst_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         busrq_n_q <= busrq_n_d;
         grant_q   <= grant_d;
      end
   end

   // Grant is qualified by busak so the DMA never drives an unacknowledged bus.
   assign grant_s     = grant_q & ~cpu_busak_n;
   assign busy        = busy_q;
   assign done        = done_q;
   assign cpu_busrq_n = busrq_n_q;

   tv80_dma_busmux u_busmux (
      .grant      (grant_s),
      .cpu_a      (cpu_a),
      .cpu_do     (cpu_do),
      .cpu_mreq_n (cpu_mreq_n),
      .cpu_wr_n   (cpu_wr_n),
      .dma_a      (dma_a_s),
      .dma_wdata  (dma_wdata_s),
      .dma_we     (dma_we_s),
      .mem_a      (mem_a),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we)
   );

`ifdef TV80_DMA_IRQ_EN
   logic int_n_q, int_n_d;

   // Sticky completion interrupt; an acknowledge beats a coincident completion.
   always_comb begin
      int_n_d = int_n_q;
      if (int_ack) begin
         int_n_d = 1'b1;
      end else if (state_d == FIN) begin
         int_n_d = 1'b0;
      end else begin
         int_n_d = int_n_q;
      end
   end

   // Interrupt flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int_n_q <= 1'b1;
      end else begin
         int_n_q <= int_n_d;
      end
   end

   assign int_n = int_n_q;
`endif

endmodule

// File: tb/tb_tv80_dma_arbiter.sv
// Scoreboard bench for tv80_dma_arbiter: a CPU stand-in, a 64 KiB memory and a
// reference model of the expected DMA write stream (TV80_DMA_IRQ_EN aware).
module tb_tv80_dma_arbiter;

   localparam int BURST_MAX = 16;
   localparam int HOLDOFF   = 4;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk, reset_n, start, mode, busy, done;
   logic [15:0] src, dst, len, cpu_a, mem_a;
   logic [7:0]  fill_val, cpu_do, mem_wdata, mem_rdata;
   logic        cpu_mreq_n, cpu_wr_n, cpu_busrq_n, cpu_busak_n, mem_we;
`ifdef TV80_DMA_IRQ_EN
   logic        int_n, int_ack;
`endif

   logic [7:0] mem    [0:65535];
   logic [7:0] shadow [0:65535];
   wr_t        exp_q[$];
   int         tsize_q[$];
   int         n_checks = 0, n_err = 0;
   int         exp_done = 0, done_cnt = 0, busrq_low_cnt = 0;
   int         tenures = 0, cmd_writes = 0;

   tv80_dma_arbiter #(.BURST_MAX(BURST_MAX), .HOLDOFF(HOLDOFF)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .src(src), .dst(dst), .len(len), .fill_val(fill_val),
      .busy(busy), .done(done),
      .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_mreq_n(cpu_mreq_n), .cpu_wr_n(cpu_wr_n),
      .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
      .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef TV80_DMA_IRQ_EN
      , .int_n(int_n), .int_ack(int_ack)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous memory: read data appears the cycle after the address.
   always @(posedge clk) begin
      if (mem_we) mem[mem_a] <= mem_wdata;
      mem_rdata <= mem[mem_a];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // CPU stand-in: acknowledges bus requests after a random delay and
   // performs random writes in 0x8000-0x8FFF only while it owns the bus.
   initial begin
      cpu_busak_n = 1'b1; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
      cpu_a = 16'h0000; cpu_do = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (!cpu_busrq_n && cpu_busak_n && ($urandom_range(0, 2) == 0)) cpu_busak_n = 1'b0;
         else if (cpu_busrq_n && !cpu_busak_n && ($urandom_range(0, 1) == 0)) cpu_busak_n = 1'b1;
         cpu_a  = 16'h8000 | 16'($urandom_range(0, 4095));
         cpu_do = 8'($urandom);
         cpu_mreq_n = cpu_busak_n ? 1'($urandom) : 1'b1;
         cpu_wr_n   = cpu_busak_n ? 1'($urandom) : 1'b1;
      end
   end

   // Monitor: port-mux checks, DMA write scoreboard, tenure and gap tracking.
   initial begin
      int  cur_bytes, gap;
      bit  had_ten;
      logic prev_busak, prev_busrq;
      wr_t e;
      cur_bytes = 0; gap = 0; had_ten = 0; prev_busak = 1'b1; prev_busrq = 1'b1;
      forever begin
         @(negedge clk);
         if (start) begin
            tenures = 0; tsize_q.delete(); cmd_writes = 0; had_ten = 0; gap = 0;
         end
         if (done) done_cnt++;
         if (!cpu_busrq_n) busrq_low_cnt++;
         if (cpu_busak_n) begin
            check("mux_addr", 32'(mem_a), 32'(cpu_a));
            check("mux_wdata", 32'(mem_wdata), 32'(cpu_do));
            check("mux_we", 32'(mem_we), 32'(!cpu_mreq_n && !cpu_wr_n));
            if (mem_we) shadow[mem_a] = mem_wdata;
         end else if (mem_we) begin
            if (exp_q.size() == 0) begin
               check("dma_write_unexpected", 32'(mem_a), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("dma_addr", 32'(mem_a), 32'(e.a));
               check("dma_data", 32'(mem_wdata), 32'(e.d));
               shadow[e.a] = e.d;
            end
            cur_bytes++;
            cmd_writes++;
         end
         if (cpu_busak_n && !prev_busak) begin
            check("tenure_le_burst_max", 32'(cur_bytes <= BURST_MAX), 32'd1);
            tsize_q.push_back(cur_bytes);
            tenures++;
            cur_bytes = 0;
            had_ten = 1;
         end
         if (cpu_busrq_n) begin
            gap++;
         end else begin
            if (prev_busrq && had_ten) check("holdoff_gap", 32'(gap >= HOLDOFF), 32'd1);
            gap = 0;
         end
         prev_busak = cpu_busak_n;
         prev_busrq = cpu_busrq_n;
      end
   end

   // Reference model: byte-by-byte ascending move over a view of memory.
   task automatic send_cmd(input logic m, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input logic [7:0] f, input bit track);
      logic [7:0]  ovr [logic [15:0]];
      logic [15:0] sa, da;
      wr_t         w;
      if (track) begin
         for (int i = 0; i < int'(l); i++) begin
            sa = s + 16'(i);
            da = d + 16'(i);
            if (m) w.d = f;
            else   w.d = ovr.exists(sa) ? ovr[sa] : shadow[sa];
            w.a = da;
            ovr[da] = w.d;
            exp_q.push_back(w);
         end
         exp_done++;
      end
      mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      int c0;
      c0 = done_cnt;
      cyc = 0;
      while (done_cnt == c0 && cyc < 4000) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      if (done_cnt == c0) check("done_timeout", 32'(cyc), 32'd0);
   endtask

   initial begin
      int cyc, b0, bad;
      reset_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
`ifdef TV80_DMA_IRQ_EN
      int_ack = 1'b0;
`endif
      for (int i = 0; i < 65536; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         mem[i] <= v;
         shadow[i] = v;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busrq_n", 32'(cpu_busrq_n), 32'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk); #1;

      send_cmd(1'b1, 16'h0000, 16'h4000, 16'd8, 8'hA5, 1'b1);
      wait_done(cyc);
      check("fill_busy_after", 32'(busy), 32'd0);
`ifdef TV80_DMA_IRQ_EN
      check("int_n_pending", 32'(int_n), 32'd0);
      repeat (3) @(posedge clk); #1;
      check("int_n_sticky", 32'(int_n), 32'd0);
      int_ack = 1'b1;
      @(posedge clk); #1;
      int_ack = 1'b0;
      check("int_n_acked", 32'(int_n), 32'd1);
`endif

      send_cmd(1'b0, 16'h1000, 16'h2000, 16'd40, 8'h00, 1'b1);
      wait_done(cyc);
      check("copy_tenures", 32'(tenures), 32'd3);
      if (tsize_q.size() == 3) begin
         check("tenure0", 32'(tsize_q[0]), 32'd16);
         check("tenure1", 32'(tsize_q[1]), 32'd16);
         check("tenure2", 32'(tsize_q[2]), 32'd8);
      end else begin
         check("tenure_list_len", 32'(tsize_q.size()), 32'd3);
      end

      send_cmd(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'h3C, 1'b1);
      wait_done(cyc);

      b0 = busrq_low_cnt;
      send_cmd(1'b1, 16'h0000, 16'h0500, 16'd0, 8'h77, 1'b1);
      wait_done(cyc);
      check("len0_latency", 32'(cyc), 32'd1);
      repeat (3) @(posedge clk); #1;
      check("len0_no_busrq", 32'(busrq_low_cnt), 32'(b0));

      send_cmd(1'b0, 16'h3000, 16'h3001, 16'd10, 8'h00, 1'b1);
      wait_done(cyc);

      send_cmd(1'b1, 16'h0000, 16'h6000, 16'd30, 8'h5A, 1'b1);
      repeat (6) @(posedge clk); #1;
      check("busy_mid_cmd", 32'(busy), 32'd1);
      send_cmd(1'b1, 16'h0000, 16'h6800, 16'd5, 8'hEE, 1'b0);
      wait_done(cyc);

      for (int k = 0; k < 6; k++) begin
         send_cmd(1'($urandom), 16'($urandom_range(0, 16'h6FFF)), 16'($urandom_range(0, 16'h6FFF)),
                  16'($urandom_range(1, 48)), 8'($urandom), 1'b1);
         wait_done(cyc);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      send_cmd(1'b1, 16'h0000, 16'h5000, 16'd30, 8'hC3, 1'b1);
      exp_done--;
      cyc = 0;
      while (cmd_writes < 3 && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      check("abort_reached_wr", 32'(cmd_writes >= 3), 32'd1);
      reset_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_busrq_n", 32'(cpu_busrq_n), 32'd1);
      check("abort_done", 32'(done), 32'd0);
      check("abort_mux_addr", 32'(mem_a), 32'(cpu_a));
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      cyc = 0;
      while (!cpu_busak_n && cyc < 100) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      check("cpu_resumes", 32'(cpu_busak_n), 32'd1);
      repeat (2) @(posedge clk); #1;
      send_cmd(1'b0, 16'h0100, 16'h0200, 16'd20, 8'h00, 1'b1);
      wait_done(cyc);

      repeat (5) @(posedge clk); #1;
      check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
      check("done_count", 32'(done_cnt), 32'(exp_done));
      bad = 0;
      for (int i = 0; i < 65536; i++) if (mem[i] !== shadow[i]) bad++;
      check("memory_image", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
